// File: rtl/wait_ram_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// wait_ram_pkg : shared state, wait-count and lane helpers for wait_ram
// Revision: 1.0
//------------------------------------------------------------------------------
package wait_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef logic [3:0] wait_cnt_t;

  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wait_ram_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// wait_ram_if : v810-style bus bundle between a bus master and wait_ram
// Revision: 1.0
//------------------------------------------------------------------------------
interface wait_ram_if #(
  parameter int DW = 32
) ();
  localparam int NB = wait_ram_pkg::lane_count(DW);

  logic          CE;
  logic          BCYSTn;
  logic          MRQn;
  logic          RW;
  logic [31:0]   A;
  logic [NB-1:0] BEn;
  logic [DW-1:0] DI;
  logic [DW-1:0] DO;
  logic          DO_OE;
  logic          READYn;
  logic          ERR;

  modport master (
    output CE, BCYSTn, MRQn, RW, A, BEn, DI,
    input  DO, DO_OE, READYn, ERR
  );

  modport slave (
    input  CE, BCYSTn, MRQn, RW, A, BEn, DI,
    output DO, DO_OE, READYn, ERR
  );
endinterface
`default_nettype wire

// File: rtl/wait_ram_array.sv
`default_nettype none
//------------------------------------------------------------------------------
// wait_ram_array : 2**AW x DW storage, async read, byte-lane write, no reset
// Revision: 1.0
//------------------------------------------------------------------------------
module wait_ram_array
  import wait_ram_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  wire logic            CLK,
  input  wire logic [DW/8-1:0] lane_we,
  input  wire logic [AW-1:0]   waddr,
  input  wire logic [DW-1:0]   wdata,
  input  wire logic [AW-1:0]   raddr,
  output logic      [DW-1:0]   rdata
);
  localparam int NB    = lane_count(DW);
  localparam int DEPTH = 2 ** AW;

  // One independent byte-wide array per lane keeps the masked write trivial
  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge CLK) begin
      if (lane_we[i]) begin
        lane_mem[waddr] <= wdata[8*i +: 8];
      end
    end

    assign rdata[8*i +: 8] = lane_mem[raddr];
  end
endmodule
`default_nettype wire

// File: rtl/wait_ram.sv
`default_nettype none
//------------------------------------------------------------------------------
// wait_ram : byte-writable RAM with a WS-cycle wait-state bus handshake.
//            Define WAIT_RAM_ERR_EN to flag and block out-of-range accesses.
// Revision: 1.0
//------------------------------------------------------------------------------
module wait_ram
  import wait_ram_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int WS = 1
) (
  input wire logic  CLK,
  input wire logic  RESn,
  wait_ram_if.slave bus
);
  localparam int        NB     = lane_count(DW);
  localparam int        LB     = $clog2(NB);
  localparam wait_cnt_t WS_CNT = wait_cnt_t'(WS);

  state_t        state_q, state_d;
  wait_cnt_t     cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [NB-1:0] ben_q, ben_d;
  logic          oor_q, oor_d;
  logic          readyn_q, readyn_d;
  logic [DW-1:0] do_q, do_d;
  logic          do_oe_q, do_oe_d;
  logic          err_q, err_d;

  logic          start, accept, enter_ack, wr_fire;
  logic          req_oor, acc_rw, acc_oor;
  logic [AW-1:0] req_addr, acc_addr;
  logic [NB-1:0] lane_we;
  logic [DW-1:0] rd_raw, rd_word;
  logic          unused_addr_bits;

  assign start    = !bus.BCYSTn && !bus.MRQn;
  assign req_addr = bus.A[AW+LB-1:LB];
  assign unused_addr_bits = ^bus.A;

`ifdef WAIT_RAM_ERR_EN
  assign req_oor = |(bus.A >> (AW + LB));
`else
  assign req_oor = 1'b0;
`endif

  assign accept    = start && ((state_q == IDLE) || (state_q == ACK));
  assign enter_ack = (accept && (WS_CNT == 4'd0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd1));

  // The access entering ACK this edge is either the one being accepted now
  // (zero wait states) or the one already latched.
  assign acc_addr = accept ? req_addr : addr_q;
  assign acc_rw   = accept ? bus.RW   : rw_q;
  assign acc_oor  = accept ? req_oor  : oor_q;

  assign wr_fire = bus.CE && RESn && (state_q == ACK) && !rw_q && !oor_q;
  assign lane_we = wr_fire ? ~ben_q : '0;

  wait_ram_array #(
    .AW (AW),
    .DW (DW)
  ) u_array (
    .CLK     (CLK),
    .lane_we (lane_we),
    .waddr   (addr_q),
    .wdata   (bus.DI),
    .raddr   (acc_addr),
    .rdata   (rd_raw)
  );

  // A back-to-back read of the word being written on this same edge must see the new bytes
  always_comb begin
    rd_word = rd_raw;
    if (addr_q == acc_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_we[i]) begin
          rd_word[8*i +: 8] = bus.DI[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    ben_d    = ben_q;
    oor_d    = oor_q;
    readyn_d = readyn_q;
    do_d     = do_q;
    do_oe_d  = do_oe_q;
    err_d    = err_q;

    if (bus.CE) begin
      if (accept) begin
        addr_d  = req_addr;
        rw_d    = bus.RW;
        ben_d   = bus.BEn;
        oor_d   = req_oor;
        cnt_d   = WS_CNT;
        state_d = (WS_CNT == 4'd0) ? ACK : WAIT;
      end else begin
        case (state_q)
          WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_d = ACK;
            end
          end
          ACK:     state_d = IDLE;
          default: state_d = state_q;
        endcase
      end

      readyn_d = !enter_ack;
      do_oe_d  = enter_ack && acc_rw;
      err_d    = enter_ack && acc_oor;
      if (enter_ack && acc_rw) begin
        do_d = acc_oor ? {DW{1'b1}} : rd_word;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      ben_q    <= '1;
      oor_q    <= 1'b0;
      readyn_q <= 1'b1;
      do_q     <= '0;
      do_oe_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      ben_q    <= ben_d;
      oor_q    <= oor_d;
      readyn_q <= readyn_d;
      do_q     <= do_d;
      do_oe_q  <= do_oe_d;
      err_q    <= err_d;
    end
  end

  assign bus.READYn = readyn_q;
  assign bus.DO     = do_q;
  assign bus.DO_OE  = do_oe_q;
  assign bus.ERR    = err_q;
endmodule
`default_nettype wire

// File: tb/tb_wait_ram.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_wait_ram : three wait_ram instances (WS = 0, 1, 3) against a word-array model
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_wait_ram;
  logic        clk = 1'b0;
  logic        resn, ce, bcystn, mrqn, rw;
  logic [31:0] a, di;
  logic [3:0]  ben;
  int          sel;

  logic [2:0]       readyn_v, do_oe_v, err_v;
  logic [2:0][31:0] do_v;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [31:0] model [int];
  logic [31:0] last_do [3];

  bit          q_rw  [8];
  logic [31:0] q_a   [8];
  logic [3:0]  q_ben [8];
  logic [31:0] q_di  [8];

  always #5 clk = ~clk;

  wait_ram_if #(.DW(32)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WSV = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    assign bus[g].CE     = ce;
    assign bus[g].BCYSTn = (sel == g) ? bcystn : 1'b1;
    assign bus[g].MRQn   = (sel == g) ? mrqn : 1'b1;
    assign bus[g].RW     = rw;
    assign bus[g].A      = a;
    assign bus[g].BEn    = ben;
    assign bus[g].DI     = di;
    assign readyn_v[g]   = bus[g].READYn;
    assign do_oe_v[g]    = bus[g].DO_OE;
    assign err_v[g]      = bus[g].ERR;
    assign do_v[g]       = bus[g].DO;

    wait_ram #(.AW(10), .DW(32), .WS(WSV)) u_dut (
      .CLK  (clk),
      .RESn (resn),
      .bus  (bus[g])
    );
  end

  function automatic int ws_of(input int inst);
    return (inst == 0) ? 0 : ((inst == 1) ? 1 : 3);
  endfunction

  function automatic bit oor(input logic [31:0] addr);
`ifdef WAIT_RAM_ERR_EN
    return (addr >> 12) != 32'd0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int key(input int inst, input logic [31:0] addr);
    return inst * 1024 + int'(addr[11:2]);
  endfunction

  function automatic logic [31:0] model_read(input int inst, input logic [31:0] addr);
    if (oor(addr)) return 32'hFFFF_FFFF;
    return model[key(inst, addr)];
  endfunction

  task automatic model_write(input int inst, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] d);
    int k;
    logic [31:0] w;
    if (!oor(addr)) begin
      k = key(inst, addr);
      w = model.exists(k) ? model[k] : 32'h0;
      for (int i = 0; i < 4; i++) if (!be[i]) w[8*i +: 8] = d[8*i +: 8];
      model[k] = w;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single access; entered and left #1 after a rising edge.
  task automatic access(input int inst, input bit r, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int ce_gap, input bit pulse, output logic [31:0] rd);
    int lat;
    sel = inst; rw = r; a = addr; ben = be; di = wd; bcystn = 1'b0; mrqn = 1'b0;
    @(posedge clk); #1;
    bcystn = 1'b1; mrqn = 1'b1; lat = 0;
    while (readyn_v[inst] === 1'b1 && lat < 40) begin
      ce = (lat < ce_gap) ? 1'b0 : 1'b1;
      if (pulse) begin bcystn = lat[0]; mrqn = lat[0]; end
      @(posedge clk); #1;
      lat++;
    end
    ce = 1'b1; bcystn = 1'b1; mrqn = 1'b1;
    chk("latency", 32'(lat), 32'(ws_of(inst) + ce_gap));
    chk("do_oe_ack", 32'(do_oe_v[inst]), 32'(r));
    chk("err_ack", 32'(err_v[inst]), 32'(oor(addr)));
    rd = do_v[inst];
    if (r) begin
      chk("read_data", rd, model_read(inst, addr));
      last_do[inst] = model_read(inst, addr);
    end else begin
      chk("do_hold_wr", do_v[inst], last_do[inst]);
      model_write(inst, addr, be, wd);
    end
    @(posedge clk); #1;
    chk("ready_pulse", 32'(readyn_v[inst]), 32'd1);
    chk("do_oe_idle", 32'(do_oe_v[inst]), 32'd0);
    chk("do_hold", do_v[inst], last_do[inst]);
  endtask

  task automatic setq(input int i, input bit r, input logic [31:0] ad,
                      input logic [3:0] be, input logic [31:0] d);
    q_rw[i] = r; q_a[i] = ad; q_ben[i] = be; q_di[i] = d;
  endtask

  // Back-to-back queue: each next start is issued during the current ACK.
  task automatic b2b(input int inst, input int n);
    int k, nk, cyc, acks, ws;
    ws = ws_of(inst); k = 0; nk = 0; cyc = 0; acks = 0;
    sel = inst; rw = q_rw[0]; a = q_a[0]; ben = q_ben[0]; di = q_di[0];
    bcystn = 1'b0; mrqn = 1'b0;
    while (acks < n && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      k = nk; di = q_di[k]; bcystn = 1'b1; mrqn = 1'b1;
      if (readyn_v[inst] === 1'b0) begin
        chk("b2b_cycle", 32'(cyc), 32'((acks + 1) * (ws + 1)));
        if (q_rw[k]) begin
          chk("b2b_rdata", do_v[inst], model_read(inst, q_a[k]));
          last_do[inst] = model_read(inst, q_a[k]);
        end else begin
          model_write(inst, q_a[k], q_ben[k], q_di[k]);
        end
        acks++;
        if (k + 1 < n) begin
          rw = q_rw[k+1]; a = q_a[k+1]; ben = q_ben[k+1];
          bcystn = 1'b0; mrqn = 1'b0; nk = k + 1;
        end
      end
    end
    chk("b2b_count", 32'(acks), 32'(n));
    @(posedge clk); #1;
    chk("b2b_idle", 32'(readyn_v[inst]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] pool [4];
    resn = 1'b0; ce = 1'b1; bcystn = 1'b1; mrqn = 1'b1; rw = 1'b1;
    a = '0; ben = '1; di = '0; sel = 0;
    for (int i = 0; i < 3; i++) last_do[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_readyn", 32'(readyn_v[i]), 32'd1);
      chk("rst_do", do_v[i], 32'h0);
      chk("rst_do_oe", 32'(do_oe_v[i]), 32'd0);
      chk("rst_err", 32'(err_v[i]), 32'd0);
    end
    resn = 1'b1;
    @(posedge clk); #1;

    // Zero-wait write then read
    access(0, 1'b0, 32'h10, 4'b0000, 32'hDEAD_BEEF, 0, 1'b0, rd);
    access(0, 1'b1, 32'h10, 4'b0000, 32'h0, 0, 1'b0, rd);
    chk("deadbeef", rd, 32'hDEAD_BEEF);

    // WS=3 read with stray strobes during WAIT
    access(2, 1'b0, 32'h10, 4'b0000, 32'h0BAD_CAFE, 0, 1'b0, rd);
    access(2, 1'b1, 32'h10, 4'b0000, 32'h0, 0, 1'b1, rd);

    // Partial store
    access(0, 1'b0, 32'h20, 4'b0000, 32'h1122_3344, 0, 1'b0, rd);
    access(0, 1'b0, 32'h20, 4'b1010, 32'hAABB_CCDD, 0, 1'b0, rd);
    access(0, 1'b1, 32'h20, 4'b0000, 32'h0, 0, 1'b0, rd);
    chk("partial", rd, 32'h11BB_33DD);

    // Back-to-back at WS=1 and WS=0 (read directly after write of same word)
    setq(0, 1'b0, 32'h30, 4'b0000, 32'hA5A5_0001);
    setq(1, 1'b1, 32'h30, 4'b1111, 32'h0);
    setq(2, 1'b0, 32'h34, 4'b0000, 32'h5A5A_0002);
    setq(3, 1'b1, 32'h34, 4'b1111, 32'h0);
    setq(4, 1'b1, 32'h30, 4'b1111, 32'h0);
    b2b(1, 5);
    setq(0, 1'b0, 32'h40, 4'b0000, 32'h0102_0304);
    setq(1, 1'b1, 32'h40, 4'b1111, 32'h0);
    setq(2, 1'b0, 32'h40, 4'b0011, 32'hF0E0_D0C0);
    setq(3, 1'b1, 32'h41, 4'b1111, 32'h0);
    setq(4, 1'b0, 32'h44, 4'b1111, 32'hFFFF_FFFF);
    b2b(0, 5);

    // CE low during WAIT stretches latency
    access(1, 1'b1, 32'h30, 4'b0000, 32'h0, 1, 1'b0, rd);
    access(2, 1'b1, 32'h10, 4'b0000, 32'h0, 2, 1'b0, rd);

    // Reset in WAIT of a write aborts it
    sel = 2; rw = 1'b0; a = 32'h10; ben = 4'b0000; di = 32'h5555_5555;
    bcystn = 1'b0; mrqn = 1'b0;
    @(posedge clk); #1;
    bcystn = 1'b1; mrqn = 1'b1;
    @(posedge clk); #1;
    resn = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_abort_readyn", 32'(readyn_v[2]), 32'd1);
    end
    resn = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_readyn", 32'(readyn_v[2]), 32'd1);
    end
    for (int i = 0; i < 3; i++) last_do[i] = 32'h0;
    chk("post_rst_do", do_v[2], 32'h0);
    chk("post_rst_do_oe", 32'(do_oe_v[2]), 32'd0);
    chk("post_rst_err", 32'(err_v[2]), 32'd0);
    access(2, 1'b1, 32'h10, 4'b0000, 32'h0, 0, 1'b0, rd);
    chk("rst_word_kept", rd, 32'h0BAD_CAFE);

    // Upper address bits: error or alias depending on the build
    access(0, 1'b0, 32'h8000_0010, 4'b0000, 32'hCAFE_F00D, 0, 1'b0, rd);
    access(0, 1'b1, 32'h10, 4'b0000, 32'h0, 0, 1'b0, rd);
`ifdef WAIT_RAM_ERR_EN
    chk("oor_no_write", rd, 32'hDEAD_BEEF);
`else
    chk("alias_write", rd, 32'hCAFE_F00D);
`endif
    access(0, 1'b1, 32'h8000_0010, 4'b0000, 32'h0, 0, 1'b0, rd);

    // Randomized traffic on a small pool of words per instance
    for (int inst = 0; inst < 3; inst++) begin
      for (int p = 0; p < 4; p++) begin
        pool[p] = 32'($urandom_range(64, 1023)) << 2;
        access(inst, 1'b0, pool[p], 4'b0000, $urandom, 0, 1'b0, rd);
      end
      for (int n = 0; n < 20; n++) begin
        logic [31:0] ad;
        ad = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) ad[31:12] = 20'($urandom);
        access(inst, 1'($urandom_range(0, 1)), ad, 4'($urandom), $urandom,
               (ws_of(inst) > 0) ? int'($urandom_range(0, 2)) : 0,
               1'($urandom_range(0, 1)), rd);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
